// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction-fetch requester
// and the MEM-stage data requester of a pipelined core.
//
// One access is granted at a time and is held until ram_ready. Data has
// priority, but fetch is forced after MAX_DSTREAK consecutive data grants
// that were made while a fetch was waiting. A watchdog abandons an access
// that waits WAIT_LIMIT cycles for ram_ready and raises a sticky error flag.
//
// Ports:
//   CLK, RST            clock (rising edge), async active-high reset
//   iREN, iaddr         instruction read request (held until ihit) + address
//   dREN, dWEN, daddr   data read/write request (held until dhit) + address
//   dstore              data write word
//   ramload, ram_ready  RAM read data and completion strobe
//   ramREN, ramWEN      RAM enables
//   ramaddr, ramstore   RAM address and write data
//   iload, ihit         fetched instruction and one-cycle fetch completion
//   dload, dhit         load data (0 for writes) and one-cycle data completion
//   timeout_err         sticky watchdog error, cleared only by RST
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int WAIT_LIMIT  = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ihit,
  output logic              dhit,
  output logic              timeout_err
);

  localparam int WAIT_W   = $clog2(WAIT_LIMIT + 1);
  localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);

  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(WAIT_LIMIT - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                d_is_write, d_is_write_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
  logic [STREAK_W-1:0] dstreak, dstreak_next;
  logic                timeout_next;
  logic                dreq;

  assign dreq = dREN | dWEN;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      d_is_write  <= 1'b0;
      wait_cnt    <= '0;
      dstreak     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      d_is_write  <= d_is_write_next;
      wait_cnt    <= wait_cnt_next;
      dstreak     <= dstreak_next;
      timeout_err <= timeout_next;
    end
  end

  // Next-state logic: arbitration in IDLE, completion/watchdog while busy.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    d_is_write_next = d_is_write;
    wait_cnt_next   = wait_cnt;
    dstreak_next    = dstreak;
    timeout_next    = timeout_err;

    case (state)
      IDLE: begin
        // Clearing here means the counter starts at zero on every grant.
        wait_cnt_next = '0;
        if (dreq && (!iREN || dstreak != STREAK_MAX)) begin
          state_next      = DACC;
          d_is_write_next = dWEN;  // dREN & dWEN together counts as a write
          if (!iREN)
            dstreak_next = '0;
          else if (dstreak != STREAK_MAX)
            dstreak_next = dstreak + STREAK_W'(1);
        end else begin
          // Either a fetch grant (forced or uncontended) or no fetch waiting:
          // both restart the data streak.
          if (iREN)
            state_next = IACC;
          dstreak_next = '0;
        end
      end

      IACC, DACC: begin
        if (ram_ready) begin
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_LAST) begin
            // The counter reaches WAIT_LIMIT on this edge: give up, no hit.
            state_next   = IDLE;
            timeout_next = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the registered state, so an asynchronous reset
  // silences the RAM port and the hits immediately. Enables follow the
  // latched grant type so a flushed request cannot turn a read into a
  // write (or abort the access) halfway through.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;

    case (state)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ram_ready) begin
          ihit  = iREN;
          iload = ramload;
        end
      end

      DACC: begin
        ramWEN   = d_is_write;
        ramREN   = ~d_is_write;
        ramaddr  = daddr;
        ramstore = dstore;
        if (ram_ready) begin
          dhit = dreq;
          if (!d_is_write)
            dload = ramload;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a directed vector table covering the
// fetch, conflict, starvation, write, flush, and watchdog scenarios, a
// hand-written reset-during-fetch sequence, then randomized traffic compared
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXD   = 4;
  localparam int WLIM   = 8;

  localparam logic [31:0] IA = 32'h0000_0040;
  localparam logic [31:0] DA = 32'h0000_0100;
  localparam logic [31:0] DS = 32'hDEAD_BEEF;
  localparam logic [31:0] RL = 32'h8C22_0004;
  localparam logic [31:0] RD = 32'h1234_5678;

  logic              CLK = 1'b0;
  logic              RST;
  logic              iREN, dREN, dWEN, ram_ready;
  logic [ADDR_W-1:0] iaddr, daddr;
  logic [DATA_W-1:0] dstore, ramload;
  logic              ramREN, ramWEN, ihit, dhit, timeout_err;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore, iload, dload;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DSTREAK(MAXD), .WAIT_LIMIT(WLIM)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .iload(iload), .dload(dload), .ihit(ihit), .dhit(dhit),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ir, dr, dw, rdy;
    logic [31:0] rl;
    logic        ren, wen;
    logic [31:0] addr, store, iload, dload;
    logic        ih, dh, te;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic ir, logic dr, logic dw, logic rdy, logic [31:0] rl,
                             logic ren, logic wen, logic [31:0] addr, logic [31:0] store,
                             logic [31:0] il, logic [31:0] dl, logic ih, logic dh, logic te);
    vec_t r;
    r.ir = ir; r.dr = dr; r.dw = dw; r.rdy = rdy; r.rl = rl;
    r.ren = ren; r.wen = wen; r.addr = addr; r.store = store;
    r.iload = il; r.dload = dl; r.ih = ih; r.dh = dh; r.te = te;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string tag, input vec_t e);
    check({tag, " ramREN"},      64'(ramREN),      64'(e.ren));
    check({tag, " ramWEN"},      64'(ramWEN),      64'(e.wen));
    check({tag, " ramaddr"},     64'(ramaddr),     64'(e.addr));
    check({tag, " ramstore"},    64'(ramstore),    64'(e.store));
    check({tag, " iload"},       64'(iload),       64'(e.iload));
    check({tag, " dload"},       64'(dload),       64'(e.dload));
    check({tag, " ihit"},        64'(ihit),        64'(e.ih));
    check({tag, " dhit"},        64'(dhit),        64'(e.dh));
    check({tag, " timeout_err"}, 64'(timeout_err), 64'(e.te));
  endtask

  // ---------------- transaction-level reference model ----------------
  // busy: 0 = no access, 1 = fetch in flight, 2 = data access in flight
  int m_busy, m_wait, m_streak;
  bit m_write, m_err;

  function automatic vec_t model_expect();
    vec_t e;
    e = v(iREN, dREN, dWEN, ram_ready, ramload, 0, 0, 0, 0, 0, 0, 0, 0, m_err);
    if (m_busy == 1) begin
      e.ren  = 1'b1;
      e.addr = iaddr;
      if (ram_ready) begin
        e.ih    = iREN;
        e.iload = ramload;
      end
    end else if (m_busy == 2) begin
      e.ren   = !m_write;
      e.wen   = m_write;
      e.addr  = daddr;
      e.store = dstore;
      if (ram_ready) begin
        e.dh    = dREN | dWEN;
        e.dload = m_write ? 32'h0 : ramload;
      end
    end
    return e;
  endfunction

  task automatic model_clock();
    if (m_busy == 0) begin
      m_wait = 0;
      if ((dREN || dWEN) && (!iREN || m_streak < MAXD)) begin
        m_busy   = 2;
        m_write  = dWEN;
        m_streak = iREN ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
      end else begin
        if (iREN) m_busy = 1;
        m_streak = 0;
      end
    end else if (ram_ready) begin
      m_busy = 0;
    end else begin
      m_wait++;
      if (m_wait == WLIM) begin
        m_busy = 0;
        m_err  = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_streak = 0; m_write = 1'b0; m_err = 1'b0;
  endtask

  task automatic drive_zero();
    iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = IA; daddr = DA; dstore = DS; ramload = 0;
  endtask

  vec_t zero_v;

  initial begin
    zero_v = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_zero();
    RST = 1'b1;
    #1;
    compare_outputs("reset", zero_v);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // ---- directed table ----
    // single fetch
    vecs.push_back(v(1,0,0,0,0,  0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,  1,0,IA,0,0,0,0,0,0));
    vecs.push_back(v(1,0,0,1,RL, 1,0,IA,0,RL,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,  0,0,0,0,0,0,0,0,0));
    // conflict: data first, one idle cycle, then fetch
    vecs.push_back(v(1,1,0,0,0,  0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(1,1,0,1,RD, 1,0,DA,DS,0,RD,0,1,0));
    vecs.push_back(v(1,0,0,0,0,  0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(1,0,0,1,RL, 1,0,IA,0,RL,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,  0,0,0,0,0,0,0,0,0));
    // starvation: four data grants, then fetch is forced
    for (int k = 0; k < MAXD; k++) begin
      vecs.push_back(v(1,1,0,0,0,  0,0,0,0,0,0,0,0,0));
      vecs.push_back(v(1,1,0,1,RD, 1,0,DA,DS,0,RD,0,1,0));
    end
    vecs.push_back(v(1,1,0,0,0,  0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(1,1,0,1,RL, 1,0,IA,0,RL,0,1,0,0));
    // streak restarted: data wins again
    vecs.push_back(v(1,1,0,0,0,  0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,1,RD, 1,0,DA,DS,0,RD,0,1,0));
    vecs.push_back(v(0,0,0,0,0,  0,0,0,0,0,0,0,0,0));
    // write, then read+write treated as write
    vecs.push_back(v(0,0,1,0,0,  0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,0,0,  0,1,DA,DS,0,0,0,0,0));
    vecs.push_back(v(0,0,1,1,RD, 0,1,DA,DS,0,0,0,1,0));
    vecs.push_back(v(0,1,1,0,0,  0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,1,1,1,RD, 0,1,DA,DS,0,0,0,1,0));
    // flush mid-fetch: access runs to completion, no ihit
    vecs.push_back(v(1,0,0,0,0,  0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,  1,0,IA,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,  1,0,IA,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,RL, 1,0,IA,0,RL,0,0,0,0));
    // ram_ready while idle is ignored
    vecs.push_back(v(0,0,0,1,RL, 0,0,0,0,0,0,0,0,0));
    // watchdog: WLIM cycles without ram_ready
    vecs.push_back(v(0,1,0,0,0,  0,0,0,0,0,0,0,0,0));
    for (int k = 0; k < WLIM; k++)
      vecs.push_back(v(0,1,0,0,0, 1,0,DA,DS,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,RL, 0,0,0,0,0,0,0,0,1));
    // start a fetch for the reset-during-access sequence
    vecs.push_back(v(1,0,0,0,0,  0,0,0,0,0,0,0,0,1));
    vecs.push_back(v(1,0,0,0,0,  1,0,IA,0,0,0,0,0,1));

    foreach (vecs[i]) begin
      @(negedge CLK);
      iREN = vecs[i].ir; dREN = vecs[i].dr; dWEN = vecs[i].dw;
      ram_ready = vecs[i].rdy; ramload = vecs[i].rl;
      #1;
      compare_outputs($sformatf("vec%0d", i), vecs[i]);
    end

    // ---- reset in the middle of a fetch ----
    @(negedge CLK);
    iREN = 1; ram_ready = 0;
    #1;
    check("pre-reset ramREN", 64'(ramREN), 64'd1);
    check("pre-reset timeout_err", 64'(timeout_err), 64'd1);
    RST = 1'b1;
    #1;
    compare_outputs("mid-access reset", zero_v);
    @(negedge CLK);
    ram_ready = 1; ramload = RL;
    #1;
    compare_outputs("held reset", zero_v);
    drive_zero();
    RST = 1'b0;
    model_reset();

    // ---- randomized traffic vs reference model ----
    for (int n = 0; n < 2000; n++) begin
      @(negedge CLK);
      iREN      = ($urandom % 4) != 0;
      dREN      = ($urandom % 3) == 0;
      dWEN      = ($urandom % 4) == 0;
      ram_ready = ($urandom % 3) == 0;
      iaddr     = $urandom;
      daddr     = $urandom;
      dstore    = $urandom;
      ramload   = $urandom;
      #1;
      compare_outputs("rand", model_expect());
      check("rand hit exclusivity", 64'(ihit & dhit), 64'd0);
      model_clock();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
